// File: rtl/usb_fifo_writer.sv
// Drains the SDRAM read-port FIFO into the FX2 slave FIFO (sync, 16-bit, AUTOIN)
// through a 2-entry prefetch buffer; commits short packets with PKTEND.
module usb_fifo_writer #(
    parameter int          PKT_WORDS = 256,
    parameter int          TIMEOUT   = 1024,
    parameter logic [1:0]  EP_ADDR   = 2'b10
) (
    input  logic        clk_read,
    input  logic        rst,
    input  logic        tx_en,
    input  logic        rdf_empty,
    input  logic [15:0] rdf_dout,
    output logic        rdf_rdreq,
    input  logic        usb_full_n,
    output logic        usb_slwr_n,
    output logic        usb_pktend_n,
    output logic [15:0] usb_fd,
    output logic [1:0]  usb_fifoaddr,
    output logic        usb_sloe_n,
    output logic [31:0] tx_word_cnt
);
    localparam int PW = $clog2(PKT_WORDS) + 1;
    localparam int IW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, STREAM, COMMIT} state_t;

    state_t           r_state, w_next;
    logic [1:0][15:0] r_buf;
    logic             r_head;
    logic [1:0]       r_occ;
    logic             r_rd_pend;
    logic [PW-1:0]    r_pkt_cnt;
    logic [IW-1:0]    r_idle_cnt;

    logic             w_fire;
    logic [1:0]       w_proj;
    logic             w_tail;
    logic             w_drained;

    assign w_fire    = (r_state == STREAM) && (r_occ != 2'd0) && usb_full_n;
    // occupancy after this edge; a read is allowed only if room remains for its word
    assign w_proj    = r_occ + {1'b0, r_rd_pend} - {1'b0, w_fire};
    assign rdf_rdreq = ~rst & tx_en & ~rdf_empty & (w_proj <= 2'd1);
    assign w_tail    = r_head ^ r_occ[0];
    assign w_drained = (r_occ == 2'd0) && !r_rd_pend;

    assign usb_fifoaddr = EP_ADDR;
    assign usb_sloe_n   = 1'b1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            // leaving on the in-flight word lets the first write fire as it lands
            IDLE:   if (r_occ != 2'd0 || r_rd_pend) w_next = STREAM;
            STREAM: begin
                if (r_pkt_cnt != '0 && w_drained &&
                    (r_idle_cnt == IW'(TIMEOUT - 1) || !tx_en))
                    w_next = COMMIT;
                else if (r_pkt_cnt == '0 && w_drained)
                    w_next = IDLE;
            end
            COMMIT: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_read) begin
        if (rst) begin
            r_state      <= IDLE;
            r_buf        <= '0;
            r_head       <= 1'b0;
            r_occ        <= 2'd0;
            r_rd_pend    <= 1'b0;
            r_pkt_cnt    <= '0;
            r_idle_cnt   <= '0;
            usb_slwr_n   <= 1'b1;
            usb_pktend_n <= 1'b1;
            usb_fd       <= 16'h0;
            tx_word_cnt  <= 32'h0;
        end else begin
            r_state      <= w_next;
            r_rd_pend    <= rdf_rdreq;
            r_occ        <= w_proj;
            usb_slwr_n   <= ~w_fire;
            usb_pktend_n <= ~(r_state == COMMIT);
            if (r_rd_pend)
                r_buf[w_tail] <= rdf_dout;
            if (w_fire) begin
                r_head      <= ~r_head;
                usb_fd      <= r_buf[r_head];
                tx_word_cnt <= tx_word_cnt + 32'd1;
                // FX2 auto-commits a full packet, so the count just wraps
                if (r_pkt_cnt == PW'(PKT_WORDS - 1))
                    r_pkt_cnt <= '0;
                else
                    r_pkt_cnt <= r_pkt_cnt + PW'(1);
            end else if (r_state == COMMIT) begin
                r_pkt_cnt <= '0;
            end
            if (w_fire || r_state == COMMIT)
                r_idle_cnt <= '0;
            else if (r_state == STREAM && r_pkt_cnt != '0 &&
                     r_idle_cnt != IW'(TIMEOUT - 1))
                r_idle_cnt <= r_idle_cnt + IW'(1);
        end
    end
endmodule

// File: tb/tb_usb_fifo_writer.sv
// Directed bench for usb_fifo_writer: source FIFO model plus a bus monitor
// that tracks strobes, PKTEND pulses and the word sequence.
module tb_usb_fifo_writer;
    localparam int TIMEOUT = 1024;

    logic        clk_read = 1'b0;
    logic        rst = 1'b1;
    logic        tx_en = 1'b1;
    logic        usb_full_n = 1'b1;
    logic        rdf_empty;
    logic [15:0] rdf_dout = 16'h0;
    logic        rdf_rdreq, usb_slwr_n, usb_pktend_n, usb_sloe_n;
    logic [15:0] usb_fd;
    logic [1:0]  usb_fifoaddr;
    logic [31:0] tx_word_cnt;

    int wr_cnt = 0, rd_ptr = 0, cyc = 0;
    int n_chk = 0, n_bad = 0;
    int strobe_cnt = 0, rdreq_cnt = 0, pktend_cnt = 0, overlap_cnt = 0, gap_cnt = 0;
    int first_rdreq_cyc = -1, first_strobe_cyc = -1, last_strobe_cyc = -1, pktend_cyc = -1;
    int exp_idx = 0;

    usb_fifo_writer #(.PKT_WORDS(256), .TIMEOUT(TIMEOUT), .EP_ADDR(2'b10)) dut (
        .clk_read(clk_read), .rst(rst), .tx_en(tx_en), .rdf_empty(rdf_empty),
        .rdf_dout(rdf_dout), .rdf_rdreq(rdf_rdreq), .usb_full_n(usb_full_n),
        .usb_slwr_n(usb_slwr_n), .usb_pktend_n(usb_pktend_n), .usb_fd(usb_fd),
        .usb_fifoaddr(usb_fifoaddr), .usb_sloe_n(usb_sloe_n), .tx_word_cnt(tx_word_cnt)
    );

    always #5 clk_read = ~clk_read;

    function automatic logic [15:0] word(input int i);
        return 16'(i * 37 + 5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // read-port FIFO: data appears the cycle after the request
    assign rdf_empty = (rd_ptr == wr_cnt);
    always @(posedge clk_read) begin
        cyc <= cyc + 1;
        if (rdf_rdreq) begin
            rdf_dout <= word(rd_ptr);
            rd_ptr   <= rd_ptr + 1;
        end
    end

    always @(negedge clk_read) begin
        if (rst) exp_idx = rd_ptr;  // words buffered at reset are discarded
        if (rdf_rdreq) begin
            rdreq_cnt++;
            if (first_rdreq_cyc < 0) first_rdreq_cyc = cyc;
        end
        if (usb_slwr_n === 1'b0) begin
            chk("fd_seq", 32'(usb_fd), 32'(word(exp_idx)));
            exp_idx++;
            if (strobe_cnt > 0 && cyc != last_strobe_cyc + 1) gap_cnt++;
            if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
            last_strobe_cyc = cyc;
            strobe_cnt++;
        end
        if (usb_pktend_n === 1'b0) begin
            pktend_cnt++;
            pktend_cyc = cyc;
        end
        if (usb_pktend_n === 1'b0 && usb_slwr_n === 1'b0) overlap_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_read);
            #1;
        end
    endtask

    task automatic wait_strobes(input int target, input int bound);
        int k = 0;
        while (strobe_cnt < target && k < bound) begin
            step(1);
            k++;
        end
        chk("wait_strobes", strobe_cnt, target);
    endtask

    task automatic wait_pktend(input int target, input int bound);
        int k = 0;
        while (pktend_cnt < target && k < bound) begin
            step(1);
            k++;
        end
        chk("wait_pktend", pktend_cnt, target);
    endtask

    initial begin
        int s0, s1, r0, r1, rp;
        wr_cnt = 512;  // preloaded while reset holds reads off
        step(3);
        chk("rst_slwr", usb_slwr_n, 1);
        chk("rst_pktend", usb_pktend_n, 1);
        chk("rst_fd", usb_fd, 0);
        chk("rst_rdreq", rdf_rdreq, 0);
        chk("rst_cnt", tx_word_cnt, 0);
        chk("fifoaddr", usb_fifoaddr, 2);
        chk("sloe_n", usb_sloe_n, 1);
        rst = 1'b0;

        // streaming 512 words
        wait_strobes(512, 700);
        step(20);
        chk("latency", first_strobe_cyc - first_rdreq_cyc, 3);
        chk("stream_gap", gap_cnt, 0);
        chk("stream_span", last_strobe_cyc - first_strobe_cyc + 1, 512);
        chk("stream_pktend", pktend_cnt, 0);
        chk("stream_cnt", tx_word_cnt, 512);

        // backpressure mid-stream, 100 words total
        wr_cnt = 612;
        wait_strobes(532, 100);
        usb_full_n = 1'b0;
        step(1);
        s0 = strobe_cnt;
        r0 = rdreq_cnt;
        step(19);
        r1 = rdreq_cnt;
        chk("bp_rdreq_stop", r1, r0);
        usb_full_n = 1'b1;
        step(1);
        s1 = strobe_cnt;
        chk("bp_no_strobe", s1, s0);

        // timeout commit of the 100-word partial packet
        wait_strobes(612, 200);
        wait_pktend(1, TIMEOUT + 50);
        step(5);
        chk("to_pulse", pktend_cnt, 1);
        chk("to_delay", pktend_cyc - last_strobe_cyc, TIMEOUT + 1);
        chk("to_cnt", tx_word_cnt, 612);

        // exact packet: no PKTEND
        wr_cnt = 868;
        wait_strobes(868, 400);
        step(2000);
        chk("exact_pktend", pktend_cnt, 1);
        chk("exact_cnt", tx_word_cnt, 868);

        // disable flush: last strobe, then COMMIT, then PKTEND
        wr_cnt = 888;
        wait_strobes(878, 100);
        r0 = rdreq_cnt;
        tx_en = 1'b0;
        step(30);
        chk("dis_no_rdreq", rdreq_cnt, r0);
        chk("dis_all_written", strobe_cnt, rd_ptr);
        chk("dis_words_left", int'(rd_ptr < wr_cnt), 1);
        chk("dis_pktend", pktend_cnt, 2);
        chk("dis_delay", pktend_cyc - last_strobe_cyc, 2);
        chk("dis_cnt", tx_word_cnt, rd_ptr);

        // reset with the buffer full
        tx_en = 1'b1;
        usb_full_n = 1'b0;
        step(6);
        rst = 1'b1;
        step(1);
        chk("mrst_slwr", usb_slwr_n, 1);
        chk("mrst_pktend", usb_pktend_n, 1);
        chk("mrst_fd", usb_fd, 0);
        chk("mrst_rdreq", rdf_rdreq, 0);
        chk("mrst_cnt", tx_word_cnt, 0);
        rp = rd_ptr;
        rst = 1'b0;
        usb_full_n = 1'b1;
        step(40);
        chk("mrst_after_cnt", tx_word_cnt, wr_cnt - rp);
        chk("mrst_no_pktend", pktend_cnt, 2);
        chk("overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
